key_debounce: RTL and testbench
===============================

Name: key_debounce

Overview:
Conditions the raw pushbutton inputs before the KEY parallel input port samples them.
- Per key: 2-flop synchroniser, then a counter-based debouncer, then press/release edge pulses.
- key_db_n drives the KEY PIO in_port directly and keeps the board's active-low polarity, so software sees a stable level.
- press_pulse and release_pulse are available to hardware consumers, e.g. the reaction timer capture.

Parameters:
- NUM_KEYS, 3: number of independent key channels.
- DEBOUNCE_CYCLES, 500000: consecutive stable clk cycles required to accept a level change (10 ms at 50 MHz); legal range is 1 or more.
- CNT_W, 19: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES-1.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- key_n_in  input  NUM_KEYS  raw pushbuttons, asynchronous, active-low (0 = pressed).
- key_db_n  output  NUM_KEYS  debounced level, active-low; feeds the KEY PIO in_port.
- press_pulse  output  NUM_KEYS  one-clk pulse on accepted press (1 to 0 transition of key_db_n).
- release_pulse  output  NUM_KEYS  one-clk pulse on accepted release (0 to 1 transition of key_db_n).

Behaviour:
- Clock and reset: clk is the clock; reset reset_n is asynchronous, active-low.
- Reset values:
  - sync stages = all 1s (released).
  - key_db_n = all 1s.
  - press_pulse = 0, release_pulse = 0.
  - all counters = 0.
- Synchroniser: per bit, sync1 <= key_n_in and sync2 <= sync1. Only sync2 is used downstream. No reset-to-X paths.
- Per-key debounce, keys fully independent with one counter each:
  - sync2 == key_db_n: counter cleared to 0. No state change.
  - sync2 != key_db_n and counter < DEBOUNCE_CYCLES-1: counter increments.
  - sync2 != key_db_n and counter == DEBOUNCE_CYCLES-1: at that edge key_db_n <= sync2, counter <= 0, and the matching pulse is asserted.
- Glitch rejection: any return of sync2 to the current key_db_n level before the count completes clears the counter. Mismatch cycles are never accumulated across glitches.
- Latency: raw change settling before clk edge E gives a key_db_n change at edge E+DEBOUNCE_CYCLES+1 (2 synchroniser stages + DEBOUNCE_CYCLES mismatch cycles, counting E as edge 1).
- Pulses:
  - Registered and asserted in the same cycle key_db_n changes.
  - High for exactly one clk; never both high for the same key.
  - A held key produces no repeat pulses.
- DEBOUNCE_CYCLES = 1: a change is accepted after a single mismatch cycle, i.e. the output follows sync2 with one extra register stage.
- Counter never wraps; it saturates conceptually at DEBOUNCE_CYCLES-1, at which point it is consumed.
- Simultaneous changes on several keys are accepted in the same cycle, and their pulses may coincide.
- Reset mid-count: the counter is discarded and the output returns to released. A key still held after reset release must debounce again: press_pulse fires after the full latency.
- Fully synchronous to clk apart from the async reset. No combinational input-to-output path.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=3, NUM_KEYS=3):
1. Clean press: key_n_in[0] 1 to 0 before edge 1, held -> key_db_n[0]=0 from edge 6; press_pulse[0]=1 for cycle after edge 6 only; other bits stay 1, no other pulses.
2. Bounce rejection: key_n_in[1] low for 3 cycles, high 1 cycle, repeated 5 times, then held low -> key_db_n[1] stays 1 through the bounces; falls 6 edges after the final stable low begins; exactly one press_pulse[1].
3. Release: after scenario 1, key_n_in[0] returns to 1 -> key_db_n[0]=1 six edges later; release_pulse[0] one cycle; no press_pulse.
4. Concurrency: keys 0 and 2 pressed on the same edge, key 1 untouched -> key_db_n=3'b010 on the same edge; press_pulse=3'b101 for one cycle.
5. Reset mid-count: key_n_in[2] low, reset_n pulsed low at cycle 4 for 2 cycles -> all outputs at reset values during reset; after release key_db_n[2] falls 6 edges after reset deassertion; single press_pulse[2].
6. Hold: key held low 100 cycles -> exactly one press_pulse, key_db_n constant 0, counter stays 0 after acceptance.

Source files
------------

// File: rtl/key_debounce.sv
// Pushbutton conditioner: per-key 2-flop synchroniser, counter debouncer,
// and registered press/release pulses. Outputs keep active-low polarity.
module key_debounce #(
  parameter int NUM_KEYS        = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_n_in,
  output logic [NUM_KEYS-1:0] key_db_n,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [NUM_KEYS-1:0] sync1_q;
  logic [NUM_KEYS-1:0] sync2_q;
  logic [NUM_KEYS-1:0] db_q;
  logic [NUM_KEYS-1:0] db_d;
  logic [NUM_KEYS-1:0] press_q;
  logic [NUM_KEYS-1:0] press_d;
  logic [NUM_KEYS-1:0] rel_q;
  logic [NUM_KEYS-1:0] rel_d;
  logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d [NUM_KEYS];

  // Any cycle where sync2 agrees with the output discards the partial count.
  always_comb begin
    db_d    = db_q;
    press_d = '0;
    rel_d   = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      cnt_d[k] = '0;
      if (sync2_q[k] != db_q[k]) begin
        if (cnt_q[k] == LAST) begin
          db_d[k]    = sync2_q[k];
          press_d[k] = ~sync2_q[k];
          rel_d[k]   = sync2_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      db_q    <= '1;
      press_q <= '0;
      rel_q   <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      sync1_q <= key_n_in;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      for (int k = 0; k < NUM_KEYS; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign key_db_n      = db_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: a window-based reference model
// predicts outputs every edge; a negedge monitor compares them.
module tb_key_debounce;

  localparam int NK = 3;
  localparam int DC = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NK-1:0] key_n_in = '1;
  logic [NK-1:0] key_db_n;
  logic [NK-1:0] press_pulse;
  logic [NK-1:0] release_pulse;

  key_debounce #(
    .NUM_KEYS(NK),
    .DEBOUNCE_CYCLES(DC),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .key_n_in(key_n_in),
    .key_db_n(key_db_n),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NK-1:0] db;
    logic [NK-1:0] pr;
    logic [NK-1:0] rl;
  } exp_t;

  exp_t          exp_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  bit            started = 0;

  // Reference: raw samples reach the debouncer two edges late; a level is
  // accepted once the last DC delivered samples since the previous
  // acceptance all differ from the current output.
  logic [NK-1:0] pipe[$];
  logic          lv[NK][$];
  logic [NK-1:0] m_db = '1;

  always @(posedge clk) begin
    exp_t          e;
    logic [NK-1:0] s;
    bit            ok;
    started = 1;
    e.pr = '0;
    e.rl = '0;
    if (!reset_n) begin
      pipe.delete();
      pipe.push_back('1);
      pipe.push_back('1);
      m_db = '1;
      for (int k = 0; k < NK; k++) lv[k].delete();
    end else begin
      s = pipe.pop_front();
      pipe.push_back(key_n_in);
      for (int k = 0; k < NK; k++) begin
        lv[k].push_back(s[k]);
        if (lv[k].size() > DC) void'(lv[k].pop_front());
        ok = (lv[k].size() == DC);
        for (int j = 0; j < lv[k].size(); j++)
          if (lv[k][j] == m_db[k]) ok = 0;
        if (ok) begin
          m_db[k] = s[k];
          e.pr[k] = ~s[k];
          e.rl[k] = s[k];
          lv[k].delete();
        end
      end
    end
    e.db = m_db;
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_empty: no expected entry at t=%0t", $time);
      end else begin
        e = exp_q.pop_front();
        if ({key_db_n, press_pulse, release_pulse} !== e) begin
          n_err++;
          $display("FAIL outputs t=%0t: got db=%b pr=%b rl=%b want db=%b pr=%b rl=%b",
                   $time, key_db_n, press_pulse, release_pulse, e.db, e.pr, e.rl);
        end
      end
    end
  end

  task automatic apply(input logic [NK-1:0] v, input int n);
    @(posedge clk);
    #2 key_n_in = v;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic pulse_reset(input int n);
    @(negedge clk);
    #1 reset_n = 1'b0;
    repeat (n) @(negedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    logic [NK-1:0] lvl;
    int            rem[NK];
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 reset_n = 1'b1;

    apply(3'b110, 12);
    apply(3'b111, 12);
    repeat (5) begin
      apply(3'b101, 3);
      apply(3'b111, 1);
    end
    apply(3'b101, 12);
    apply(3'b111, 12);
    apply(3'b010, 12);
    apply(3'b111, 12);
    apply(3'b011, 4);
    pulse_reset(2);
    apply(3'b011, 12);
    apply(3'b111, 12);
    apply(3'b110, 100);
    apply(3'b111, 12);

    lvl = '1;
    for (int k = 0; k < NK; k++) rem[k] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NK; k++) begin
        if (rem[k] == 0) begin
          lvl[k] = ~lvl[k];
          if ($urandom_range(0, 2) == 0) rem[k] = $urandom_range(1, DC);
          else rem[k] = $urandom_range(DC, DC + 10);
        end
        rem[k]--;
      end
      apply(lvl, 1);
      if ($urandom_range(0, 399) == 0) pulse_reset($urandom_range(1, 3));
    end

    apply('1, 12);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
